fetch_unit: RTL and testbench

Instruction fetch stage for the soft processor. Owns the program counter, drives the word address into `InstructionMemory`, and pairs each returned instruction with its PC. It delivers instructions to decode over a valid/ready handshake. Decode/execute can redirect the PC on taken branches and jumps, and the core can halt fetch. A one-entry hold buffer absorbs decode back-pressure, so no instruction is lost or duplicated.

---
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, pairs memory data with its PC and
// hands instructions to decode through a one-entry hold buffer.
module fetch_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] pc,
  input  logic [31:0]     inst,
  input  logic            halt,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            dec_ready,
  output logic            if_valid,
  output logic [31:0]     if_inst,
  output logic [PC_W-1:0] if_pc,
  output logic [31:0]     fetch_count
);

  typedef enum logic {RUN, HALT} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            req_vld_q, req_vld_d;
  logic [PC_W-1:0] hold_pc_q, hold_pc_d;
  logic [31:0]     hold_inst_q, hold_inst_d;
  logic            hold_vld_q, hold_vld_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            accept;
  logic            stall;

  always_comb begin
    if_valid = 1'b0;
    if_inst  = '0;
    if_pc    = '0;
    if (hold_vld_q) begin
      if_valid = 1'b1;
      if_inst  = hold_inst_q;
      if_pc    = hold_pc_q;
    end else if (req_vld_q) begin
      if_valid = 1'b1;
      if_inst  = inst;
      if_pc    = req_pc_q;
    end
  end

  assign accept      = if_valid && dec_ready;
  assign stall       = if_valid && !dec_ready;
  assign pc          = pc_q;
  assign fetch_count = cnt_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_vld_d   = req_vld_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    hold_vld_d  = hold_vld_q;
    cnt_d       = cnt_q;

    if (accept)
      cnt_d = cnt_q + 32'd1;

    case (state_q)
      RUN:     state_d = halt ? HALT : RUN;
      HALT:    state_d = halt ? HALT : RUN;
      default: state_d = RUN;
    endcase

    // A redirect flushes even an instruction accepted on this edge.
    if (redirect) begin
      pc_d       = redirect_pc;
      req_vld_d  = 1'b0;
      hold_vld_d = 1'b0;
    end else if (stall && !hold_vld_q) begin
      hold_pc_d   = req_pc_q;
      hold_inst_d = inst;
      hold_vld_d  = 1'b1;
      req_vld_d   = 1'b0;
    end else if (stall) begin
      hold_vld_d = 1'b1;
    end else if (state_d == RUN) begin
      pc_d       = pc_q + 1'b1;
      req_pc_d   = pc_q;
      req_vld_d  = 1'b1;
      hold_vld_d = 1'b0;
    end else begin
      req_vld_d  = 1'b0;
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_vld_q   <= 1'b0;
      hold_pc_q   <= '0;
      hold_inst_q <= '0;
      hold_vld_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_vld_q   <= req_vld_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
      hold_vld_q  <= hold_vld_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] fetch_count;

  logic        rst2_n;
  logic [3:0]  pc2;
  logic [31:0] inst2;
  logic        if_valid2;
  logic [31:0] if_inst2;
  logic [3:0]  if_pc2;
  logic [31:0] fetch_count2;

  logic [31:0] mem  [64];
  logic [31:0] mem2 [16];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) inst  <= mem[pc[5:0]];
  always @(posedge clk) inst2 <= mem2[pc2];

  fetch_unit #(.PC_W(32), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .inst(inst),
    .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_ready(dec_ready), .if_valid(if_valid), .if_inst(if_inst),
    .if_pc(if_pc), .fetch_count(fetch_count)
  );

  fetch_unit #(.PC_W(4), .RESET_PC(4'd14)) dut2 (
    .clk(clk), .rst_n(rst2_n), .pc(pc2), .inst(inst2),
    .halt(1'b0), .redirect(1'b0), .redirect_pc(4'd0),
    .dec_ready(1'b1), .if_valid(if_valid2), .if_inst(if_inst2),
    .if_pc(if_pc2), .fetch_count(fetch_count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dec_ready = 1'b1;
    repeat (2) tick();
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %0b want 0", if_valid); end
    n_cmp++; if (pc !== 32'd0) begin n_bad++; $display("FAIL rst_pc got %0d want 0", pc); end
    n_cmp++; if (fetch_count !== 32'd0) begin n_bad++; $display("FAIL rst_cnt got %0d want 0", fetch_count); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd0) begin n_bad++; $display("FAIL c1_pc got v=%0b pc=%0d want v=1 pc=0", if_valid, if_pc); end
    n_cmp++; if (if_inst !== 32'h014B6020) begin n_bad++; $display("FAIL c1_inst got %h want 014b6020", if_inst); end
    tick();
    n_cmp++; if (if_pc !== 32'd1 || if_inst !== 32'h000C6042) begin n_bad++; $display("FAIL c2 got pc=%0d inst=%h want pc=1 inst=000c6042", if_pc, if_inst); end
    n_cmp++; if (fetch_count !== 32'd1) begin n_bad++; $display("FAIL c2_cnt got %0d want 1", fetch_count); end
  endtask

  task automatic test_back_pressure();
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd1 || if_inst !== 32'h000C6042) begin n_bad++; $display("FAIL bp_hold%0d got v=%0b pc=%0d inst=%h want v=1 pc=1 inst=000c6042", i, if_valid, if_pc, if_inst); end
      n_cmp++; if (pc !== 32'd2) begin n_bad++; $display("FAIL bp_pc%0d got %0d want 2", i, pc); end
    end
    dec_ready = 1'b1;
    n_cmp++; if (if_pc !== 32'd1) begin n_bad++; $display("FAIL bp_rel got %0d want 1", if_pc); end
    for (int i = 2; i <= 3; i++) begin
      tick();
      n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'(i) || if_inst !== (32'hA000_0000 | 32'(i))) begin n_bad++; $display("FAIL bp_seq got v=%0b pc=%0d inst=%h want pc=%0d", if_valid, if_pc, if_inst, i); end
    end
    n_cmp++; if (fetch_count !== 32'd3) begin n_bad++; $display("FAIL bp_cnt got %0d want 3", fetch_count); end
  endtask

  task automatic test_redirect();
    repeat (2) tick();
    n_cmp++; if (if_pc !== 32'd5) begin n_bad++; $display("FAIL rd_pre got %0d want 5", if_pc); end
    redirect = 1'b1;
    redirect_pc = 32'd40;
    tick();
    redirect = 1'b0;
    n_cmp++; if (if_valid !== 1'b0 || if_pc !== 32'd0 || if_inst !== 32'd0) begin n_bad++; $display("FAIL rd_bubble got v=%0b pc=%0d inst=%h want 0", if_valid, if_pc, if_inst); end
    n_cmp++; if (fetch_count !== 32'd6) begin n_bad++; $display("FAIL rd_cnt got %0d want 6", fetch_count); end
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd40 || if_inst !== 32'hA000_0028) begin n_bad++; $display("FAIL rd_tgt got v=%0b pc=%0d inst=%h want pc=40", if_valid, if_pc, if_inst); end
    tick();
    n_cmp++; if (if_pc !== 32'd41) begin n_bad++; $display("FAIL rd_next got %0d want 41", if_pc); end
    n_cmp++; if (fetch_count !== 32'd7) begin n_bad++; $display("FAIL rd_cnt2 got %0d want 7", fetch_count); end
  endtask

  task automatic test_redirect_stall();
    dec_ready = 1'b0;
    tick();
    n_cmp++; if (if_pc !== 32'd41 || pc !== 32'd42) begin n_bad++; $display("FAIL rs_hold got pc=%0d fpc=%0d want 41/42", if_pc, pc); end
    redirect = 1'b1;
    redirect_pc = 32'd10;
    tick();
    redirect = 1'b0;
    dec_ready = 1'b1;
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rs_bubble got %0b want 0", if_valid); end
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd10) begin n_bad++; $display("FAIL rs_tgt got v=%0b pc=%0d want pc=10", if_valid, if_pc); end
    n_cmp++; if (fetch_count !== 32'd7) begin n_bad++; $display("FAIL rs_cnt got %0d want 7", fetch_count); end
  endtask

  task automatic test_halt();
    redirect = 1'b1;
    redirect_pc = 32'd3;
    tick();
    redirect = 1'b0;
    tick();
    n_cmp++; if (if_pc !== 32'd3) begin n_bad++; $display("FAIL h_pre got %0d want 3", if_pc); end
    halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (if_valid !== 1'b0 || pc !== 32'd4) begin n_bad++; $display("FAIL h_idle%0d got v=%0b pc=%0d want v=0 pc=4", i, if_valid, pc); end
    end
    n_cmp++; if (fetch_count !== 32'd9) begin n_bad++; $display("FAIL h_cnt got %0d want 9", fetch_count); end
    halt = 1'b0;
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd4) begin n_bad++; $display("FAIL h_resume got v=%0b pc=%0d want pc=4", if_valid, if_pc); end
    halt = 1'b1;
    tick();
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL h2_idle got %0b want 0", if_valid); end
    redirect = 1'b1;
    redirect_pc = 32'd20;
    tick();
    redirect = 1'b0;
    tick();
    n_cmp++; if (if_valid !== 1'b0 || pc !== 32'd20) begin n_bad++; $display("FAIL h2_rd got v=%0b pc=%0d want v=0 pc=20", if_valid, pc); end
    halt = 1'b0;
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd20) begin n_bad++; $display("FAIL h2_resume got v=%0b pc=%0d want pc=20", if_valid, if_pc); end
  endtask

  task automatic test_wrap();
    rst2_n = 1'b1;
    tick();
    n_cmp++; if (if_valid2 !== 1'b1 || if_pc2 !== 4'd14 || if_inst2 !== 32'hB000_000E) begin n_bad++; $display("FAIL wr14 got v=%0b pc=%0d inst=%h", if_valid2, if_pc2, if_inst2); end
    tick();
    n_cmp++; if (if_pc2 !== 4'd15) begin n_bad++; $display("FAIL wr15 got %0d want 15", if_pc2); end
    tick();
    n_cmp++; if (if_pc2 !== 4'd0 || if_inst2 !== 32'hB000_0000) begin n_bad++; $display("FAIL wr0 got pc=%0d inst=%h want 0", if_pc2, if_inst2); end
  endtask

  task automatic test_async_reset();
    dec_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (if_valid !== 1'b0 || if_inst !== 32'd0 || if_pc !== 32'd0) begin n_bad++; $display("FAIL ar_out got v=%0b pc=%0d inst=%h want 0", if_valid, if_pc, if_inst); end
    n_cmp++; if (pc !== 32'd0 || fetch_count !== 32'd0) begin n_bad++; $display("FAIL ar_state got pc=%0d cnt=%0d want 0", pc, fetch_count); end
    tick();
    rst_n = 1'b1;
    dec_ready = 1'b1;
    tick();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_inst !== 32'h014B6020) begin n_bad++; $display("FAIL ar_restart got v=%0b pc=%0d inst=%h", if_valid, if_pc, if_inst); end
    tick();
    n_cmp++; if (if_pc !== 32'd1) begin n_bad++; $display("FAIL ar_next got %0d want 1", if_pc); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    for (int i = 0; i < 16; i++) mem2[i] = 32'hB000_0000 | 32'(i);
    mem[0] = 32'h014B6020;
    mem[1] = 32'h000C6042;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    halt = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    dec_ready = 1'b1;
    test_reset();
    test_back_pressure();
    test_redirect();
    test_redirect_stall();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
